// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch prefetcher, its bus interface and the bench.
package fetch_pkg;

    localparam int FetchXLen  = 32;
    localparam int InstrBytes = 4;

    typedef struct packed {
        logic [FetchXLen-1:0] pc;
        logic [31:0]          instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_prefetcher_if.sv
// Memory request/response bus plus the write/pop/flush side of the downstream fetch FIFO.
interface fetch_prefetcher_if import fetch_pkg::*; #(
    parameter int XLen = FetchXLen
) ();

    logic               req_valid;
    logic               req_ready;
    logic [XLen-1:0]    req_addr;
    logic               rsp_valid;
    logic [31:0]        rsp_data;
    logic               fifo_we;
    fetch_entry_t       fifo_w_data;
    logic               fifo_pop;
    logic               flush;

    modport master (
        output req_valid, req_addr, fifo_we, fifo_w_data, flush,
        input  req_ready, rsp_valid, rsp_data, fifo_pop
    );

    modport slave (
        input  req_valid, req_addr, fifo_we, fifo_w_data, flush,
        output req_ready, rsp_valid, rsp_data, fifo_pop
    );

endinterface

// File: rtl/fetch_prefetcher_counter.sv
// Up/down counter with a synchronous load that takes priority over counting.
module fetch_prefetcher_counter #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_up,
    input  logic             i_down,
    output logic [Width-1:0] o_count
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_count <= i_load_val;
        end else begin
            r_count <= r_count + Width'(i_up) - Width'(i_down);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetcher.sv
// Sequential instruction prefetcher: issues fetches against reserved FIFO credits,
// writes in-order responses tagged with their PC, and squashes stale traffic on redirect.
module fetch_prefetcher import fetch_pkg::*; #(
    parameter int              XLen           = FetchXLen,
    parameter logic [XLen-1:0] ResetPc        = XLen'(0),
    parameter int              LogDepth       = 4,
    parameter int              MaxOutstanding = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 redirect,
    input  logic [XLen-1:0]      redirect_pc,
    fetch_prefetcher_if.master   bus,
    output logic                 busy
);

    localparam int                CreditW   = LogDepth + 1;
    localparam int                OutW      = $clog2(MaxOutstanding) + 1;
    localparam logic [CreditW-1:0] CreditMax = CreditW'(2 ** LogDepth);
    localparam logic [OutW-1:0]    OutMax    = OutW'(MaxOutstanding);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [XLen-1:0]   r_req_pc;
    logic [XLen-1:0]   r_rsp_pc;
    logic [CreditW-1:0] w_credits;
    logic [OutW-1:0]   w_outstanding;
    logic [OutW-1:0]   w_drop_cnt;
    logic [OutW-1:0]   w_drop_load_val;
    logic              w_req_valid;
    logic              w_fire;
    logic              w_drop;
    logic              w_write;
    logic              w_pop;
    logic              w_rsp;
    fetch_entry_t      w_entry;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_req_valid = enable && !redirect && (w_credits != '0) &&
                              (w_outstanding != OutMax);
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (!rst) begin
            w_req_valid = 1'b0;
        end
    end

    assign w_fire  = w_req_valid && bus.req_ready;
    assign w_rsp   = rst && bus.rsp_valid;
    assign w_drop  = w_rsp && (redirect || (w_drop_cnt != '0));
    assign w_write = w_rsp && !redirect && (w_drop_cnt == '0);
    assign w_pop   = rst && bus.fifo_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_pc <= ResetPc;
            r_rsp_pc <= ResetPc;
        end else if (redirect) begin
            r_req_pc <= redirect_pc;
            r_rsp_pc <= redirect_pc;
        end else begin
            if (w_fire) begin
                r_req_pc <= r_req_pc + XLen'(InstrBytes);
            end
            if (w_write) begin
                r_rsp_pc <= r_rsp_pc + XLen'(InstrBytes);
            end
        end
    end

    // The redirect reload frees every reserved slot at once, so responses squashed
    // afterwards have nothing left to return to the credit pool.
    fetch_prefetcher_counter #(.Width(CreditW)) u_credits (
        .clk        (clk),
        .i_load     (!rst || redirect),
        .i_load_val (CreditMax),
        .i_up       (w_pop),
        .i_down     (w_fire),
        .o_count    (w_credits)
    );

    fetch_prefetcher_counter #(.Width(OutW)) u_outstanding (
        .clk        (clk),
        .i_load     (!rst),
        .i_load_val ('0),
        .i_up       (w_fire),
        .i_down     (w_rsp),
        .o_count    (w_outstanding)
    );

    assign w_drop_load_val = rst ? (w_outstanding - OutW'(bus.rsp_valid)) : '0;

    fetch_prefetcher_counter #(.Width(OutW)) u_drop_cnt (
        .clk        (clk),
        .i_load     (!rst || redirect),
        .i_load_val (w_drop_load_val),
        .i_up       (1'b0),
        .i_down     (w_drop),
        .o_count    (w_drop_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst && bus.rsp_valid) begin
            assert (w_outstanding != '0);
        end
    end

    assign w_entry.pc    = r_rsp_pc;
    assign w_entry.instr = bus.rsp_data;

    assign bus.req_valid   = w_req_valid;
    assign bus.req_addr    = rst ? r_req_pc : ResetPc;
    assign bus.fifo_we     = w_write;
    assign bus.fifo_w_data = rst ? w_entry : '0;
    assign bus.flush       = rst && redirect;
    assign busy            = rst && (w_outstanding != '0);

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Directed vector table, directed sequences and randomized traffic for fetch_prefetcher,
// checked against a queue-based model of the memory bus and the downstream FIFO.
module tb_fetch_prefetcher;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        busy;

    fetch_prefetcher_if #(.XLen(32)) bus ();

    fetch_prefetcher #(
        .XLen(32), .ResetPc(32'h0), .LogDepth(4), .MaxOutstanding(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rs, en, rd;
        logic [31:0] rpc;
        logic        rdy, rsp, pop;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wpc;
        logic        e_fl, e_busy;
    } vec_t;

    function automatic vec_t v(input logic rs, en, rd, input logic [31:0] rpc,
                               input logic rdy, rsp, pop, input logic rv,
                               input logic [31:0] addr, input logic we,
                               input logic [31:0] wpc, input logic fl, bz);
        vec_t r;
        r.rs = rs; r.en = en; r.rd = rd; r.rpc = rpc;
        r.rdy = rdy; r.rsp = rsp; r.pop = pop;
        r.e_rv = rv; r.e_addr = addr; r.e_we = we; r.e_wpc = wpc;
        r.e_fl = fl; r.e_busy = bz;
        return r;
    endfunction

    vec_t tbl [16];

    // ---------------- model of memory bus and FIFO ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          stale;
        int          ready;
    } flight_t;

    flight_t     fl_q[$];
    logic [63:0] fifo_q[$];
    bit          m_run = 0;
    logic [31:0] m_pc = 32'h0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          want_pop = 0;

    int          n_req = 0;
    logic [31:0] last_wpc = 32'hFFFF_FFFF;
    logic [31:0] first_wpc = 32'hFFFF_FFFF;
    bit          first_set = 0;
    bit          track200 = 0;
    bit          seen_200 = 0;

    task automatic tick();
        logic        e_rv;
        logic        e_we;
        int          live;
        int          rdy_at;
        logic [31:0] pc_w;
        bus.rsp_valid = rst && (fl_q.size() > 0) && (fl_q.size() > 0 ? fl_q[0].ready <= cyc : 1'b0);
        bus.rsp_data  = bus.rsp_valid ? fl_q[0].data : 32'h0;
        bus.fifo_pop  = rst && want_pop && (fifo_q.size() > 0);
        #1;
        live = 0;
        foreach (fl_q[k]) if (!fl_q[k].stale) live++;
        e_rv = rst && m_run && enable && !redirect &&
               ((16 - fifo_q.size() - live) > 0) && (fl_q.size() < 4);
        e_we = bus.rsp_valid ? (!redirect && !fl_q[0].stale) : 1'b0;
        chk("req_valid", bus.req_valid, e_rv);
        chk("req_addr", bus.req_addr, rst ? m_pc : 32'h0);
        chk("fifo_we", bus.fifo_we, e_we);
        chk("flush", bus.flush, rst && redirect);
        chk("busy", busy, rst && (fl_q.size() != 0));
        if (e_we) chk("fifo_w_data", bus.fifo_w_data, {fl_q[0].addr, fl_q[0].data});
        if (bus.fifo_we) chk("fifo_room", fifo_q.size() < 16, 1'b1);
        if (bus.req_valid && bus.req_ready) n_req++;
        if (bus.fifo_we) begin
            pc_w = bus.fifo_w_data.pc;
            last_wpc = pc_w;
            if (!first_set) begin
                first_wpc = pc_w;
                first_set = 1;
            end
            if (track200 && pc_w >= 32'h200 && pc_w < 32'h300) seen_200 = 1;
        end
        @(posedge clk);
        if (!rst) begin
            m_run = 0;
            m_pc  = 32'h0;
            fl_q.delete();
            fifo_q.delete();
        end else begin
            if (bus.fifo_pop) void'(fifo_q.pop_front());
            if (bus.rsp_valid) begin
                if (e_we) fifo_q.push_back({fl_q[0].addr, fl_q[0].data});
                void'(fl_q.pop_front());
            end
            if (redirect) begin
                fifo_q.delete();
                foreach (fl_q[k]) fl_q[k].stale = 1;
                m_pc = redirect_pc;
            end
            if (e_rv && bus.req_ready) begin
                rdy_at = cyc + $urandom_range(lat_max, lat_min);
                if (fl_q.size() > 0 && fl_q[fl_q.size()-1].ready > rdy_at)
                    rdy_at = fl_q[fl_q.size()-1].ready;
                fl_q.push_back('{addr: m_pc, data: $urandom(), stale: 1'b0, ready: rdy_at});
                m_pc = m_pc + 32'd4;
            end
            if (enable) m_run = 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0; enable = 0; redirect = 0; want_pop = 0; bus.req_ready = 0;
        tick();
        rst = 1;
    endtask

    initial begin
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_data = 0; bus.fifo_pop = 0;

        //          rs en rd rpc         rdy rsp pop  rv addr        we wpc         fl bz
        tbl[0]  = v(0, 0, 0, 32'h0,      0,  0,  0,   0, 32'h0,      0, 32'h0,      0, 0);
        tbl[1]  = v(1, 1, 0, 32'h0,      1,  0,  0,   0, 32'h0,      0, 32'h0,      0, 0);
        tbl[2]  = v(1, 1, 0, 32'h0,      1,  0,  0,   1, 32'h0,      0, 32'h0,      0, 0);
        tbl[3]  = v(1, 1, 0, 32'h0,      1,  0,  0,   1, 32'h4,      0, 32'h0,      0, 1);
        tbl[4]  = v(1, 1, 0, 32'h0,      0,  0,  0,   1, 32'h8,      0, 32'h0,      0, 1);
        tbl[5]  = v(1, 1, 0, 32'h0,      1,  0,  0,   1, 32'h8,      0, 32'h0,      0, 1);
        tbl[6]  = v(1, 1, 1, 32'h1000,   1,  0,  0,   0, 32'hC,      0, 32'h0,      1, 1);
        tbl[7]  = v(1, 1, 0, 32'h0,      1,  1,  0,   1, 32'h1000,   0, 32'h0,      0, 1);
        tbl[8]  = v(1, 1, 0, 32'h0,      1,  1,  0,   1, 32'h1004,   0, 32'h0,      0, 1);
        tbl[9]  = v(1, 1, 0, 32'h0,      1,  1,  0,   1, 32'h1008,   0, 32'h0,      0, 1);
        tbl[10] = v(1, 1, 0, 32'h0,      0,  1,  0,   1, 32'h100C,   1, 32'h1000,   0, 1);
        tbl[11] = v(1, 1, 1, 32'h2000,   1,  1,  1,   0, 32'h100C,   0, 32'h0,      1, 1);
        tbl[12] = v(1, 1, 0, 32'h0,      0,  0,  0,   1, 32'h2000,   0, 32'h0,      0, 1);
        tbl[13] = v(1, 1, 0, 32'h0,      1,  1,  0,   1, 32'h2000,   0, 32'h0,      0, 1);
        tbl[14] = v(1, 1, 0, 32'h0,      0,  1,  0,   1, 32'h2004,   1, 32'h2000,   0, 1);
        tbl[15] = v(1, 0, 0, 32'h0,      0,  0,  0,   0, 32'h2004,   0, 32'h0,      0, 0);

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rs; enable = tbl[i].en; redirect = tbl[i].rd;
            redirect_pc = tbl[i].rpc; bus.req_ready = tbl[i].rdy;
            bus.rsp_valid = tbl[i].rsp; bus.rsp_data = 32'hC0DE_0000 + 32'(i);
            bus.fifo_pop = tbl[i].pop;
            #1;
            chk($sformatf("v%0d_req_valid", i), bus.req_valid, tbl[i].e_rv);
            chk($sformatf("v%0d_req_addr", i), bus.req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_fifo_we", i), bus.fifo_we, tbl[i].e_we);
            chk($sformatf("v%0d_flush", i), bus.flush, tbl[i].e_fl);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_we)
                chk($sformatf("v%0d_w_data", i), bus.fifo_w_data,
                    {tbl[i].e_wpc, 32'hC0DE_0000 + 32'(i)});
            @(posedge clk);
            @(negedge clk);
        end

        // Fill the FIFO from reset with a one-cycle memory and an idle consumer.
        lat_min = 1; lat_max = 1;
        do_reset();
        enable = 1; bus.req_ready = 1; n_req = 0; first_set = 0;
        repeat (40) tick();
        chk("t1_nreq", n_req, 16);
        chk("t1_firstpc", first_wpc, 32'h0);
        chk("t1_lastpc", last_wpc, 32'h3C);
        chk("t1_stalled", bus.req_valid, 1'b0);

        // Free one slot.
        n_req = 0;
        want_pop = 1; tick(); want_pop = 0;
        repeat (6) tick();
        chk("t2_nreq", n_req, 1);
        chk("t2_pc", last_wpc, 32'h40);

        // Back-to-back redirects; only the second stream may reach the FIFO.
        lat_min = 2; lat_max = 3;
        do_reset();
        enable = 1; bus.req_ready = 1; want_pop = 1;
        repeat (8) tick();
        redirect = 1; redirect_pc = 32'h200; track200 = 1; seen_200 = 0;
        tick();
        redirect = 0; tick();
        redirect = 1; redirect_pc = 32'h300; first_set = 0; first_wpc = 32'hFFFF_FFFF;
        tick();
        redirect = 0;
        repeat (20) tick();
        chk("t5_first", first_wpc, 32'h300);
        chk("t5_no200", seen_200, 1'b0);
        track200 = 0;

        // Stall, then reset mid-operation; IDLE must hold until enable returns.
        lat_min = 1; lat_max = 1;
        do_reset();
        enable = 1; bus.req_ready = 1; want_pop = 1;
        repeat (6) tick();
        bus.req_ready = 0;
        repeat (10) tick();
        rst = 0; tick();
        rst = 1; enable = 0;
        repeat (3) tick();
        enable = 1; bus.req_ready = 1;
        tick();
        repeat (4) tick();

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 299) != 0);
            enable        = ($urandom_range(0, 9) != 0);
            bus.req_ready = ($urandom_range(0, 9) < 7);
            want_pop      = ($urandom_range(0, 9) < 4);
            redirect      = ($urandom_range(0, 39) == 0);
            redirect_pc   = $urandom() & 32'hFFFF_FFFC;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
